// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the CPU datapath and the
// loader/debug port, inserting WAIT wait states per access and stalling the CPU.
module mem_port_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {GNT_LD = 1'b0, GNT_CPU = 1'b1} grant_e;

  localparam logic [7:0] WAIT_CNT = 8'(WAIT);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  grant_e        last_grant_q, last_grant_d;
  grant_e        grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // NOTE: every _d gets its hold value first so no path through the case leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          // On a tie the requester that was not served last time wins.
          if (cpu_req && (!ld_req || last_grant_q == GNT_LD)) grant_d = GNT_CPU;
          else                                                 grant_d = GNT_LD;
          last_grant_d = grant_d;
          we_d         = (grant_d == GNT_CPU) ? cpu_we    : ld_we;
          addr_d       = (grant_d == GNT_CPU) ? cpu_addr  : ld_addr;
          wdata_d      = (grant_d == GNT_CPU) ? cpu_wdata : ld_wdata;
          cnt_d        = WAIT_CNT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 8'd0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the
  // pre-edge values of one another.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= GNT_LD;
      grant_q      <= GNT_LD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == RESP) && (grant_q == GNT_CPU);
  assign ld_ack    = (state_q == RESP) && (grant_q == GNT_LD);
  // Both read ports mirror the capture register; only the acked one is meaningful.
  assign cpu_rdata = rdata_q;
  assign ld_rdata  = rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level timing/memory model.
module tb_mem_port_arbiter;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0, ld_rdata;
  logic        ld_ack;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem   [256];

  // Second and third instances exercise the WAIT extremes with the CPU port only.
  logic        aux_req [2];
  logic [31:0] aux_addr [2];
  logic [31:0] aux_rdata [2], aux_ld_rdata [2], aux_maddr [2], aux_mwdata [2], aux_mrdata [2];
  logic        aux_ack [2], aux_stall [2], aux_ld_ack [2], aux_en [2], aux_we [2], aux_busy [2];

  int checks = 0;
  int errors = 0;
  int ec = 0;

  // Reference model state: one outstanding transaction and the alternation memory.
  bit          m_busy = 1'b0, m_cpu = 1'b0, m_last_cpu = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_start = 0;
  bit          log_cpu [$];
  int          log_ec [$];

  always #5 clk = ~clk;

  assign mem_rdata     = slave_mem[mem_addr[9:2]];
  assign aux_mrdata[0] = aux_maddr[0] ^ 32'h5A5A_0F0F;
  assign aux_mrdata[1] = aux_maddr[1] ^ 32'h5A5A_0F0F;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(WAIT)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(0)) u_w0 (
    .clk(clk), .reset(rst),
    .cpu_req(aux_req[0]), .cpu_we(1'b0), .cpu_addr(aux_addr[0]), .cpu_wdata(32'd0),
    .cpu_rdata(aux_rdata[0]), .cpu_ack(aux_ack[0]), .cpu_stall(aux_stall[0]),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'd0), .ld_wdata(32'd0),
    .ld_rdata(aux_ld_rdata[0]), .ld_ack(aux_ld_ack[0]),
    .mem_en(aux_en[0]), .mem_we(aux_we[0]), .mem_addr(aux_maddr[0]), .mem_wdata(aux_mwdata[0]),
    .mem_rdata(aux_mrdata[0]), .busy(aux_busy[0])
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT(255)) u_w255 (
    .clk(clk), .reset(rst),
    .cpu_req(aux_req[1]), .cpu_we(1'b0), .cpu_addr(aux_addr[1]), .cpu_wdata(32'd0),
    .cpu_rdata(aux_rdata[1]), .cpu_ack(aux_ack[1]), .cpu_stall(aux_stall[1]),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'd0), .ld_wdata(32'd0),
    .ld_rdata(aux_ld_rdata[1]), .ld_ack(aux_ld_ack[1]),
    .mem_en(aux_en[1]), .mem_we(aux_we[1]), .mem_addr(aux_maddr[1]), .mem_wdata(aux_mwdata[1]),
    .mem_rdata(aux_mrdata[1]), .busy(aux_busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  // Model grant decision for the coming edge, based on the inputs that edge will see.
  task automatic model_decide();
    if (!rst && !m_busy && (cpu_req || ld_req)) begin
      if (cpu_req && ld_req) m_cpu = !m_last_cpu;
      else                   m_cpu = cpu_req;
      m_last_cpu = m_cpu;
      m_we    = m_cpu ? cpu_we    : ld_we;
      m_addr  = m_cpu ? cpu_addr  : ld_addr;
      m_wdata = m_cpu ? cpu_wdata : ld_wdata;
      m_start = ec + 1;
      m_busy  = 1'b1;
    end
  endtask

  // Compare this cycle's outputs with the model: an access granted at edge s has
  // mem_en after edges s..s+WAIT, its ack after edge s+WAIT+1, and is idle again after s+WAIT+2.
  task automatic model_check();
    bit e_en, e_cack, e_lack, e_busy;
    int d;
    e_en = 0; e_cack = 0; e_lack = 0; e_busy = 0;
    if (m_busy && (ec - m_start) >= WAIT + 2) m_busy = 1'b0;
    if (m_busy) begin
      d      = ec - m_start;
      e_busy = 1'b1;
      e_en   = (d <= WAIT);
      if (d == WAIT + 1) begin
        e_cack = m_cpu;
        e_lack = !m_cpu;
      end
    end
    check("busy", busy, e_busy);
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_en && m_we);
    if (e_en) begin
      check("mem_addr", mem_addr, m_addr);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("cpu_ack", cpu_ack, e_cack);
    check("ld_ack", ld_ack, e_lack);
    check("cpu_stall", cpu_stall, cpu_req && !e_cack);
    if (e_cack && !m_we) check("cpu_rdata", cpu_rdata, ref_mem[m_addr[9:2]]);
    if (e_lack && !m_we) check("ld_rdata", ld_rdata, ref_mem[m_addr[9:2]]);
    if ((e_cack || e_lack) && m_we) ref_mem[m_addr[9:2]] = m_wdata;
    if (cpu_ack) begin log_cpu.push_back(1'b1); log_ec.push_back(ec); end
    if (ld_ack)  begin log_cpu.push_back(1'b0); log_ec.push_back(ec); end
    if (mem_en && mem_we) slave_mem[mem_addr[9:2]] = mem_wdata;
  endtask

  task automatic step();
    model_decide();
    @(posedge clk);
    ec++;
    @(negedge clk);
    model_check();
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_last_cpu = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input bit want_cpu, output int edges, output int en_cnt,
                          output int we_cnt, output int oth_cnt);
    bit got;
    got = 0; edges = 0; en_cnt = 0; we_cnt = 0; oth_cnt = 0;
    while (!got && edges < 40) begin
      step();
      edges++;
      en_cnt  += int'(mem_en);
      we_cnt  += int'(mem_we);
      oth_cnt += want_cpu ? int'(ld_ack) : int'(cpu_ack);
      got = want_cpu ? cpu_ack : ld_ack;
    end
    check(want_cpu ? "cpu_ack_seen" : "ld_ack_seen", got, 1);
  endtask

  task automatic aux_read(input int i, input int w, input logic [31:0] addr);
    int edges, en;
    bit got;
    edges = 0; en = 0; got = 0;
    aux_addr[i] = addr;
    aux_req[i]  = 1'b1;
    while (!got && edges < w + 10) begin
      step();
      edges++;
      en += int'(aux_en[i]);
      got = aux_ack[i];
    end
    check("aux_ack_seen", got, 1);
    check("aux_latency", edges, w + 2);
    check("aux_en_cycles", en, w + 1);
    check("aux_rdata", aux_rdata[i], addr ^ 32'h5A5A_0F0F);
    check("aux_stall_at_ack", aux_stall[i], 0);
    aux_req[i] = 1'b0;
    step();
    check("aux_idle", aux_busy[i], 0);
  endtask

  initial begin
    int edges, en_cnt, we_cnt, oth_cnt;
    logic [31:0] v;

    aux_req[0] = 1'b0; aux_req[1] = 1'b0;
    aux_addr[0] = '0;  aux_addr[1] = '0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      ref_mem[i]   = v;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ld_ack", ld_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ld_rdata", ld_rdata, 0);
    rst = 1'b0;
    ec  = 0;
    model_reset();
    step();

    // 1: CPU read of 0x40
    slave_mem[8'h10] = 32'h1234_5678;
    ref_mem[8'h10]   = 32'h1234_5678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    wait_ack(1'b1, edges, en_cnt, we_cnt, oth_cnt);
    check("t1_latency", edges, WAIT + 2);
    check("t1_en_cycles", en_cnt, WAIT + 1);
    check("t1_rdata", cpu_rdata, 32'h1234_5678);
    check("t1_stall_at_ack", cpu_stall, 0);
    cpu_req = 1'b0;
    step();

    // 2: loader write then CPU read-back
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_wdata = 32'hDEAD_BEEF;
    wait_ack(1'b0, edges, en_cnt, we_cnt, oth_cnt);
    check("t2_latency", edges, WAIT + 2);
    check("t2_we_cycles", we_cnt, WAIT + 1);
    check("t2_no_cpu_ack", oth_cnt, 0);
    ld_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    wait_ack(1'b1, edges, en_cnt, we_cnt, oth_cnt);
    check("t2_readback", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    step();

    // 3: both held continuously from reset -> strict alternation, CPU first
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = rand_addr();
    log_cpu.delete(); log_ec.delete();
    for (int n = 0; n < 30 && log_cpu.size() < 4; n++) step();
    check("t3_ack_count", log_cpu.size(), 4);
    if (log_cpu.size() >= 4) begin
      check("t3_grant0", log_cpu[0], 1);
      check("t3_grant1", log_cpu[1], 0);
      check("t3_grant2", log_cpu[2], 1);
      check("t3_grant3", log_cpu[3], 0);
      for (int j = 1; j < 4; j++) check("t3_spacing", log_ec[j] - log_ec[j-1], WAIT + 3);
    end
    ld_req = 1'b0;
    wait_ack(1'b1, edges, en_cnt, we_cnt, oth_cnt);
    cpu_req = 1'b0;
    step();

    // 4: WAIT extremes
    aux_read(0, 0, 32'h0000_0A0C);
    aux_read(1, 255, 32'h0000_0330);

    // 5: reset during the second ACCESS cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rand_addr();
    step();
    step();
    check("t5_in_access", mem_en, 1);
    rst = 1'b1;
    #1;
    check("t5_mem_en", mem_en, 0);
    check("t5_busy", busy, 0);
    check("t5_cpu_ack", cpu_ack, 0);
    check("t5_ld_ack", ld_ack, 0);
    check("t5_mem_we", mem_we, 0);
    model_reset();
    step();
    rst = 1'b0;
    wait_ack(1'b1, edges, en_cnt, we_cnt, oth_cnt);
    check("t5_restart_latency", edges, WAIT + 2);
    check("t5_restart_en", en_cnt, WAIT + 1);
    cpu_req = 1'b0;
    step();

    // 6: CPU waits behind a loader access
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = rand_addr(); ld_wdata = $urandom;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ld_addr;
    edges = 0;
    while (!ld_ack && edges < 20) begin
      step();
      edges++;
      check("t6_stall", cpu_stall, 1);
    end
    check("t6_ld_ack_seen", ld_ack, 1);
    ld_req = 1'b0;
    wait_ack(1'b1, edges, en_cnt, we_cnt, oth_cnt);
    check("t6_cpu_latency", edges, WAIT + 3);
    check("t6_readback", cpu_rdata, ld_wdata);
    cpu_req = 1'b0;
    step();

    // Random traffic from both requesters, each holding its request until acked
    for (int n = 0; n < 600; n++) begin
      step();
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (ld_req && ld_ack)   ld_req  = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = $urandom;
      end
      if (!ld_req && $urandom_range(0, 2) == 0) begin
        ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = rand_addr(); ld_wdata = $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
